maxnet_controller: RTL and testbench
====================================

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 Parameter PU_LATENCY, default 2: cycles between an a-register load and valid PU outputs; legal range 0..15.
REQ-002 Parameter MAX_ITER, default 255: iteration limit used only when MAXNET_TIMEOUT_EN is defined; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to run one winner-take-all computation.
REQ-006 is_finished  input  1  datapath flag: at most one a-register is non-zero.
REQ-007 init_x  output  1  initialise the X memory.
REQ-008 init_w  output  1  initialise the W memory.
REQ-009 load_a  output  1  load enable for the four a-registers.
REQ-010 load_sel  output  1  a-register source: 1 = X memory, 0 = PU outputs.
REQ-011 busy  output  1  computation in progress.
REQ-012 done  output  1  result valid on the datapath res output.
REQ-013 iter_count  output  8  number of PU update iterations performed.
REQ-014 timeout  output  1  computation ended on the iteration limit.

Function
REQ-015 The FSM SHALL have the states IDLE, INIT, LOAD_X, CHECK, WAIT, UPDATE and DONE; all outputs SHALL be registered-state decodes (Moore).
REQ-016 IDLE: all outputs 0; start=1 -> INIT; start=0 -> stay in IDLE.
REQ-017 INIT (1 cycle): init_x=1, init_w=1, busy=1, iter_count cleared to 0, timeout cleared to 0; -> LOAD_X.
REQ-018 LOAD_X (1 cycle): load_a=1, load_sel=1, busy=1; -> CHECK.
REQ-019 CHECK (1 cycle): busy=1; is_finished=1 -> DONE; otherwise -> WAIT when PU_LATENCY>0, or directly -> UPDATE when PU_LATENCY=0.
REQ-020 WAIT: busy=1, load_a=0; an internal 4-bit counter SHALL hold the FSM for exactly PU_LATENCY cycles and then -> UPDATE; the counter SHALL clear on entry.
REQ-021 UPDATE (1 cycle): load_a=1, load_sel=0, busy=1; iter_count increments by 1 and saturates at 255; -> CHECK.
REQ-022 Per-iteration period SHALL be PU_LATENCY+2 cycles (CHECK, WAIT, UPDATE).
REQ-023 DONE: done=1, busy=0; iter_count and timeout SHALL hold their values; start=1 -> INIT (restart); start=0 -> stay in DONE.
REQ-024 start SHALL be ignored in INIT, LOAD_X, CHECK, WAIT and UPDATE.
REQ-025 is_finished SHALL be sampled only in CHECK.
REQ-026 load_sel SHALL be 0 in every state except LOAD_X.
REQ-027 init_x and init_w SHALL be 1 only in INIT.

Reset
REQ-028 rst=1 SHALL force IDLE asynchronously, including in mid-operation.
REQ-029 While rst=1, all outputs SHALL be 0, iter_count SHALL be 0 and the WAIT counter SHALL be 0.
REQ-030 After rst is released, the first transition SHALL occur on the next rising clk edge.

Configuration
REQ-031 Macro MAXNET_TIMEOUT_EN defined: in CHECK, when is_finished=0 and iter_count=MAX_ITER, the FSM SHALL go to DONE and set timeout=1; is_finished=1 takes priority and gives timeout=0.
REQ-032 Macro MAXNET_TIMEOUT_EN undefined: there is no iteration limit, timeout SHALL be tied to 0, and MAX_ITER SHALL be unused.

Verification
REQ-033 rst pulse, then start=1 for one cycle with is_finished held at 1 -> INIT, LOAD_X, CHECK, DONE; done=1 on cycle 4 after start; iter_count=0.
REQ-034 PU_LATENCY=2, is_finished rises after 3 UPDATEs -> each iteration takes 4 cycles; done=1 with iter_count=3; load_sel=1 only during LOAD_X.
REQ-035 PU_LATENCY=0, is_finished=1 after 5 UPDATEs -> CHECK and UPDATE alternate every cycle; done with iter_count=5.
REQ-036 MAXNET_TIMEOUT_EN defined, MAX_ITER=4, is_finished stuck at 0 -> DONE after the 4th UPDATE; timeout=1, iter_count=4; without the macro, still busy after 300 iterations and iter_count=255.
REQ-037 rst asserted during WAIT of iteration 2 -> all outputs 0 immediately, without waiting for clk; after release and start=1, the run restarts from INIT with iter_count=0.
REQ-038 start toggled during busy, then start=1 in DONE -> no effect while busy; from DONE, INIT is entered on the next cycle and done drops to 0.

Source files
------------

// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for a four-neuron MAXNET winner-take-all datapath.
// Initialises the X/W memories, loads the a-registers from X, then repeats
// CHECK -> WAIT (PU_LATENCY cycles) -> UPDATE until the datapath reports that
// at most one a-register is non-zero.
// Optional feature: define MAXNET_TIMEOUT_EN to stop after MAX_ITER updates
// and flag the run with timeout=1.
module maxnet_controller #(
    parameter int PU_LATENCY = 2,
    parameter int MAX_ITER   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_finished,
    output logic       init_x,
    output logic       init_w,
    output logic       load_a,
    output logic       load_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] iter_count,
    output logic       timeout
);

    // Elaboration-time range checks on the configuration.
    if (PU_LATENCY < 0 || PU_LATENCY > 15) begin : g_bad_latency
        $error("maxnet_controller: PU_LATENCY must be in 0..15");
    end
    if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
        $error("maxnet_controller: MAX_ITER must be in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD_X,
        CHECK,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    // Last value of the WAIT counter before leaving for UPDATE.
    localparam logic [3:0] WAIT_LAST = (PU_LATENCY > 0) ? 4'(PU_LATENCY - 1) : 4'd0;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       limit_hit;

`ifdef MAXNET_TIMEOUT_EN
    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);
    assign limit_hit = (iter_count == ITER_LIMIT);
`else
    assign limit_hit = 1'b0;
`endif

    // State register; reset forces IDLE at once, even mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decode of the current state.
    always_comb begin
        state_next = state;
        init_x     = 1'b0;
        init_w     = 1'b0;
        load_a     = 1'b0;
        load_sel   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = INIT;
            end
            INIT: begin
                init_x     = 1'b1;
                init_w     = 1'b1;
                busy       = 1'b1;
                state_next = LOAD_X;
            end
            LOAD_X: begin
                load_a     = 1'b1;
                load_sel   = 1'b1;
                busy       = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                // A finished datapath wins over the iteration limit.
                if (is_finished) begin
                    state_next = DONE;
                end else if (limit_hit) begin
                    state_next = DONE;
                end else if (PU_LATENCY == 0) begin
                    state_next = UPDATE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) state_next = UPDATE;
            end
            UPDATE: begin
                load_a     = 1'b1;
                busy       = 1'b1;
                state_next = CHECK;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = INIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // WAIT counter: zero outside WAIT so every WAIT visit starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Iteration counter: cleared as INIT is entered, bumped once per UPDATE, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_count <= 8'd0;
        end else if (state_next == INIT) begin
            iter_count <= 8'd0;
        end else if (state == UPDATE && iter_count != 8'hFF) begin
            iter_count <= iter_count + 8'd1;
        end
    end

`ifdef MAXNET_TIMEOUT_EN
    // Timeout flag: cleared as INIT is entered, set when CHECK leaves on the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (state_next == INIT) begin
            timeout <= 1'b0;
        end else if (state == CHECK && !is_finished && limit_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller (PU_LATENCY=2, MAX_ITER=4).
// The driver pushes the expected completion of each run; the monitor emulates
// the datapath's is_finished flag and checks every completion it observes.
`timescale 1ns/1ps
module tb_maxnet_controller;
    localparam int LAT  = 2;
    localparam int MAXI = 4;
`ifdef MAXNET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       is_finished;
    logic       init_x, init_w, load_a, load_sel, busy, done, timeout;
    logic [7:0] iter_count;

    typedef struct {
        int iter;
        bit to;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   t0         = 0;
    int   target     = 0;
    int   updates    = 0;
    int   ls_pulses  = 0;
    int   done_count = 0;
    logic prev_done  = 1'b0;

    maxnet_controller #(.PU_LATENCY(LAT), .MAX_ITER(MAXI)) dut (
        .clk(clk), .rst(rst), .start(start), .is_finished(is_finished),
        .init_x(init_x), .init_w(init_w), .load_a(load_a), .load_sel(load_sel),
        .busy(busy), .done(done), .iter_count(iter_count), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: datapath emulation plus scoreboard comparison on each completion.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            prev_done   = 1'b0;
            is_finished = 1'b0;
        end else begin
            if (init_x) begin
                updates   = 0;
                ls_pulses = 0;
            end
            if (load_a && !load_sel) updates++;
            if (load_sel) ls_pulses++;
            is_finished = (updates >= target);
            if (load_sel) chk("load_sel_needs_load_a_busy", int'(load_a & busy), 1);
            if (init_x || init_w) chk("init_outputs_alone", int'({init_x, init_w, load_a, done}), 12);
            if (done) chk("done_excludes_busy", int'({busy, load_a, load_sel}), 0);
            if (done && !prev_done) begin
                done_count++;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_done: got done=1, expected no completion pending (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("iter_count", int'(iter_count), e.iter);
                    chk("timeout", int'(timeout), int'(e.to));
                    chk("latency", cyc - t0, e.lat);
                    chk("update_pulses", updates, e.iter);
                    chk("load_x_pulses", ls_pulses, 1);
                end
            end
            prev_done = done;
        end
    end

    // Issue one start pulse; t0 marks the edge that samples it.
    task automatic issue(input int n);
        target = n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    // One complete run with n datapath updates before is_finished rises.
    task automatic run(input int n, input bit toggle);
        exp_t e;
        int   snap;
        e.iter = n;
        e.to   = 1'b0;
        if (TO_EN && n > MAXI) begin
            e.iter = MAXI;
            e.to   = 1'b1;
        end
        e.lat = 3 + e.iter * (LAT + 2);
        snap  = done_count;
        sb.push_back(e);
        issue(n);
        @(negedge clk);
        #1;
        chk("init_entered", int'(init_x), 1);
        chk("done_dropped", int'(done), 0);
        chk("iter_cleared", int'(iter_count), 0);
        chk("busy_in_init", int'(busy), 1);
        for (int k = 0; k < e.lat + 12; k++) begin
            if (done_count != snap) break;
            start = (toggle && (cyc - t0) < e.lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        if (done_count == snap) begin
            compared++;
            mismatched++;
            $display("FAIL run_completion: no done within %0d cycles, expected done after %0d", e.lat + 12, e.lat);
            sb.delete();
        end else begin
            repeat (2) begin
                @(negedge clk);
                #1;
                chk("done_holds", int'(done), 1);
                chk("iter_holds", int'(iter_count), e.iter);
                chk("timeout_holds", int'(timeout), int'(e.to));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", int'({init_x, init_w, load_a, load_sel, busy, done, timeout}), 0);
        chk("reset_iter", int'(iter_count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_holds", int'({busy, done, init_x}), 0);

        run(0, 1'b0);
        run(3, 1'b0);
        run(5, 1'b0);
        run(0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            run(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
        end
        run(MAXI, 1'b1);

        // Asynchronous reset in the WAIT phase of the second iteration.
        issue(5);
        @(negedge clk);
        #1;
        start = 1'b0;
        while ((cyc - t0) < 2 + (LAT + 2) + 1) begin
            @(negedge clk);
            #1;
        end
        chk("wait_iter2_count", int'(iter_count), 1);
        chk("wait_iter2_outputs", int'({busy, load_a, done}), 4);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({init_x, init_w, load_a, load_sel, busy, done, timeout}), 0);
        chk("async_reset_iter", int'(iter_count), 0);
        @(negedge clk);
        rst = 1'b0;
        run(2, 1'b0);

`ifdef MAXNET_TIMEOUT_EN
        run(1000, 1'b0);
`else
        issue(1000000);
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (300 * (LAT + 2)) @(negedge clk);
        #1;
        chk("unbounded_busy", int'({busy, done, timeout}), 4);
        chk("unbounded_saturated", int'(iter_count), 255);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
